// File: rtl/bram_arbiter_if.sv
// Requester and bram-side signal bundle for bram_arbiter. The arbiter connects
// through the slave modport; the requesters and bram model connect through master.
interface bram_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             p0_valid;
  logic             p0_ready;
  logic [WIDTH-1:0] p0_addr;
  logic [31:0]      p0_wdata;
  logic [3:0]       p0_wmask;
  logic [31:0]      p0_rdata;

  logic             p1_valid;
  logic             p1_ready;
  logic [WIDTH-1:0] p1_addr;
  logic [31:0]      p1_wdata;
  logic [3:0]       p1_wmask;
  logic [31:0]      p1_rdata;

  logic [WIDTH-1:0] bram_addr;
  logic [31:0]      bram_wdata;
  logic [3:0]       bram_wmask;
  logic [31:0]      bram_rdata;

  modport slave (
    input  p0_valid, p0_addr, p0_wdata, p0_wmask,
    output p0_ready, p0_rdata,
    input  p1_valid, p1_addr, p1_wdata, p1_wmask,
    output p1_ready, p1_rdata,
    output bram_addr, bram_wdata, bram_wmask,
    input  bram_rdata
  );

  modport master (
    output p0_valid, p0_addr, p0_wdata, p0_wmask,
    input  p0_ready, p0_rdata,
    output p1_valid, p1_addr, p1_wdata, p1_wmask,
    input  p1_ready, p1_rdata,
    input  bram_addr, bram_wdata, bram_wmask,
    output bram_rdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port, byte-masked, 1-cycle-latency bram.
// Fixed priority (port 0 wins) by default; define BRAM_ARB_RR_EN for round-robin.
module bram_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  bram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;   // 0 = port 0, 1 = port 1
  logic [WIDTH-1:0] addr_q,  addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;

  logic any_valid;
  logic win;

  assign any_valid = bus.p0_valid | bus.p1_valid;

`ifdef BRAM_ARB_RR_EN
  logic last_q, last_d;

  // On a tie the port that was not served last wins; a lone requester always wins.
  assign win    = (bus.p0_valid & bus.p1_valid) ? ~last_q : ~bus.p0_valid;
  assign last_d = (state_q == IDLE && any_valid) ? win : last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign win = ~bus.p0_valid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      // NOTE: non-blocking so every register sees the pre-edge values of the others.
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case leaves a latch.
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = win;
          addr_d  = win ? bus.p1_addr  : bus.p0_addr;
          wdata_d = win ? bus.p1_wdata : bus.p0_wdata;
          wmask_d = win ? bus.p1_wmask : bus.p0_wmask;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and data simply hold the latched request; only the mask is gated,
  // so the bram can never see a write outside the ISSUE cycle.
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.bram_wmask = (state_q == ISSUE) ? wmask_q : 4'b0000;

  assign bus.p0_ready = (state_q == WAIT) & ~grant_q;
  assign bus.p1_ready = (state_q == WAIT) &  grant_q;
  assign bus.p0_rdata = bus.p0_ready ? bus.bram_rdata : 32'd0;
  assign bus.p1_rdata = bus.p1_ready ? bus.bram_rdata : 32'd0;

endmodule
